// File: rtl/sram_sp_arb_pkg.sv
// Shared types for the two-port SRAM arbiter: port index, stage-1 record
// and the two-way round-robin pick.
package sram_sp_arb_pkg;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   typedef struct packed {
      logic  val;
      port_e port;
      logic  we;
   } stage1_t;

   // elig[i] marks port i eligible; last is the port granted most recently.
   function automatic logic [1:0] rr_grant(input logic [1:0] elig, input logic last);
      logic [1:0] g;
      g = 2'b00;
      case (elig)
         2'b01:   g = 2'b01;
         2'b10:   g = 2'b10;
         2'b11:   g = last ? 2'b01 : 2'b10;
         default: g = 2'b00;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous-read SRAM: one access per enabled cycle, read data
// registered and valid the cycle after the access.
module sram_sp #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     en,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [WIDTH-1:0]         di,
   output logic [WIDTH-1:0]         dout
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [WIDTH-1:0] dout_r;

   // Storage is deliberately not reset so contents survive a controller reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_r[addr] <= di;
         end
         dout_r <= mem_r[addr];
      end
   end

   assign dout = dout_r;

endmodule

// File: rtl/sram_sp_arb.sv
// Round-robin arbiter and sequencer sharing one single-port SRAM between two
// valid/ready requesters, with per-port registered responses.
module sram_sp_arb
   import sram_sp_arb_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     P0_REQ_VAL,
   output logic                     P0_REQ_RDY,
   input  logic                     P0_REQ_WE,
   input  logic [$clog2(DEPTH)-1:0] P0_REQ_ADDR,
   input  logic [WIDTH-1:0]         P0_REQ_WDATA,
   output logic                     P0_RSP_VAL,
   input  logic                     P0_RSP_RDY,
   output logic [WIDTH-1:0]         P0_RSP_RDATA,
   input  logic                     P1_REQ_VAL,
   output logic                     P1_REQ_RDY,
   input  logic                     P1_REQ_WE,
   input  logic [$clog2(DEPTH)-1:0] P1_REQ_ADDR,
   input  logic [WIDTH-1:0]         P1_REQ_WDATA,
   output logic                     P1_RSP_VAL,
   input  logic                     P1_RSP_RDY,
   output logic [WIDTH-1:0]         P1_RSP_RDATA
);

   localparam int AW = $clog2(DEPTH);

   logic [1:0]       elig_s;
   logic [1:0]       grant_s;
   logic [1:0]       rsp_hs_s;
   logic             last_r;
   logic [1:0]       pend_r;
   stage1_t          s1_r;
   logic             rsp_val0_r;
   logic             rsp_val1_r;
   logic [WIDTH-1:0] rdata0_r;
   logic [WIDTH-1:0] rdata1_r;

   logic             sram_en_s;
   logic             sram_we_s;
   logic [AW-1:0]    sram_addr_s;
   logic [WIDTH-1:0] sram_di_s;
   logic [WIDTH-1:0] sram_do_s;

   // A port whose response is being consumed this cycle may issue again.
   always_comb begin
      rsp_hs_s[0] = rsp_val0_r & P0_RSP_RDY;
      rsp_hs_s[1] = rsp_val1_r & P1_RSP_RDY;
      elig_s[0]   = P0_REQ_VAL & (~pend_r[0] | rsp_hs_s[0]);
      elig_s[1]   = P1_REQ_VAL & (~pend_r[1] | rsp_hs_s[1]);
      if (RST) begin
         grant_s = 2'b00;
      end else begin
         grant_s = rr_grant(elig_s, last_r);
      end
   end

   // SRAM port follows the granted requester; fields default to port 0.
   always_comb begin
      sram_en_s = |grant_s;
      if (grant_s[1]) begin
         sram_we_s   = P1_REQ_WE;
         sram_addr_s = P1_REQ_ADDR;
         sram_di_s   = P1_REQ_WDATA;
      end else begin
         sram_we_s   = P0_REQ_WE;
         sram_addr_s = P0_REQ_ADDR;
         sram_di_s   = P0_REQ_WDATA;
      end
   end

   // Arbitration pointer, outstanding flags and stage-1 tracking.
   always_ff @(posedge CLK) begin
      if (RST) begin
         last_r  <= 1'b1;
         pend_r  <= 2'b00;
         s1_r    <= '0;
      end else begin
         if (sram_en_s) begin
            last_r <= grant_s[1];
         end
         for (int i = 0; i < 2; i++) begin
            if (grant_s[i]) begin
               pend_r[i] <= 1'b1;
            end else if (rsp_hs_s[i]) begin
               pend_r[i] <= 1'b0;
            end
         end
         s1_r.val  <= sram_en_s;
         s1_r.port <= grant_s[1] ? PORT1 : PORT0;
         s1_r.we   <= sram_we_s;
      end
   end

   // Response registers: loaded when stage 1 completes, held until handshake.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rsp_val0_r <= 1'b0;
         rsp_val1_r <= 1'b0;
         rdata0_r   <= '0;
         rdata1_r   <= '0;
      end else begin
         if (s1_r.val && (s1_r.port == PORT0)) begin
            rsp_val0_r <= 1'b1;
            rdata0_r   <= s1_r.we ? {WIDTH{1'b0}} : sram_do_s;
         end else if (rsp_hs_s[0]) begin
            rsp_val0_r <= 1'b0;
         end
         if (s1_r.val && (s1_r.port == PORT1)) begin
            rsp_val1_r <= 1'b1;
            rdata1_r   <= s1_r.we ? {WIDTH{1'b0}} : sram_do_s;
         end else if (rsp_hs_s[1]) begin
            rsp_val1_r <= 1'b0;
         end
      end
   end

   sram_sp #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_sram (
      .clk  (CLK),
      .en   (sram_en_s),
      .we   (sram_we_s),
      .addr (sram_addr_s),
      .di   (sram_di_s),
      .dout (sram_do_s)
   );

   assign P0_REQ_RDY   = grant_s[0];
   assign P1_REQ_RDY   = grant_s[1];
   assign P0_RSP_VAL   = rsp_val0_r;
   assign P1_RSP_VAL   = rsp_val1_r;
   assign P0_RSP_RDATA = rdata0_r;
   assign P1_RSP_RDATA = rdata1_r;

endmodule

// File: tb/tb_sram_sp_arb.sv
// Scoreboard bench for sram_sp_arb: a transaction-level model predicts grants
// and responses; a negedge monitor compares what the DUT presents.
module tb_sram_sp_arb;

   localparam int WIDTH = 32;
   localparam int DEPTH = 1024;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p0_val = 1'b0, p0_we = 1'b0, p0_rsp_rdy = 1'b1;
   logic        p1_val = 1'b0, p1_we = 1'b0, p1_rsp_rdy = 1'b1;
   logic [9:0]  p0_addr = 10'd0, p1_addr = 10'd0;
   logic [31:0] p0_wdata = 32'd0, p1_wdata = 32'd0;
   wire         p0_rdy, p1_rdy, p0_rsp_val, p1_rsp_val;
   wire  [31:0] p0_rdata, p1_rdata;

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   int          cyc = 0;
   bit          armed = 1'b0;
   logic        m_last = 1'b1;
   logic [31:0] mem [DEPTH];
   exp_t        q0[$];
   exp_t        q1[$];

   sram_sp_arb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK(clk), .RST(rst),
      .P0_REQ_VAL(p0_val), .P0_REQ_RDY(p0_rdy), .P0_REQ_WE(p0_we),
      .P0_REQ_ADDR(p0_addr), .P0_REQ_WDATA(p0_wdata),
      .P0_RSP_VAL(p0_rsp_val), .P0_RSP_RDY(p0_rsp_rdy), .P0_RSP_RDATA(p0_rdata),
      .P1_REQ_VAL(p1_val), .P1_REQ_RDY(p1_rdy), .P1_REQ_WE(p1_we),
      .P1_REQ_ADDR(p1_addr), .P1_REQ_WDATA(p1_wdata),
      .P1_RSP_VAL(p1_rsp_val), .P1_RSP_RDY(p1_rsp_rdy), .P1_RSP_RDATA(p1_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Model rule: a port is free when nothing is outstanding (a response taken
   // this cycle has already been retired); on conflict the other-than-last wins.
   function automatic logic [1:0] exp_grant();
      logic e0, e1;
      e0 = p0_val && (q0.size() == 0);
      e1 = p1_val && (q1.size() == 0);
      if (rst) return 2'b00;
      if (e0 && e1) return m_last ? 2'b01 : 2'b10;
      return {e1, e0};
   endfunction

   // Predictor: records each accept with its data and due cycle.
   always @(posedge clk) begin
      logic [1:0] g;
      exp_t e;
      if (rst) begin
         q0.delete();
         q1.delete();
         m_last = 1'b1;
         armed  = 1'b1;
      end else if (armed) begin
         g = exp_grant();
         if (g[0]) begin
            e.data = p0_we ? 32'd0 : mem[p0_addr];
            e.due  = cyc + 2;
            q0.push_back(e);
            if (p0_we) mem[p0_addr] = p0_wdata;
            m_last = 1'b0;
         end
         if (g[1]) begin
            e.data = p1_we ? 32'd0 : mem[p1_addr];
            e.due  = cyc + 2;
            q1.push_back(e);
            if (p1_we) mem[p1_addr] = p1_wdata;
            m_last = 1'b1;
         end
      end
      cyc++;
   end

   // Monitor: compares presented responses and grants against the model.
   always @(negedge clk) begin
      if (armed) begin
         logic mv;
         logic [1:0] eg;
         mv = (q0.size() > 0) && (cyc >= q0[0].due);
         check(p0_rsp_val === mv, "p0_rsp_val", {31'd0, p0_rsp_val}, {31'd0, mv});
         if (mv) begin
            check(p0_rdata === q0[0].data, "p0_rsp_rdata", p0_rdata, q0[0].data);
            if (p0_rsp_rdy) void'(q0.pop_front());
         end
         mv = (q1.size() > 0) && (cyc >= q1[0].due);
         check(p1_rsp_val === mv, "p1_rsp_val", {31'd0, p1_rsp_val}, {31'd0, mv});
         if (mv) begin
            check(p1_rdata === q1[0].data, "p1_rsp_rdata", p1_rdata, q1[0].data);
            if (p1_rsp_rdy) void'(q1.pop_front());
         end
         eg = exp_grant();
         check({p1_rdy, p0_rdy} === eg, "grant", {30'd0, p1_rdy, p0_rdy}, {30'd0, eg});
         check(!(p1_rdy && p0_rdy), "single_grant", {30'd0, p1_rdy, p0_rdy}, 32'd0);
      end
   end

   // Issue one request on port p; called and returns at posedge+1.
   task automatic req(input int p, input bit we, input int addr, input logic [31:0] d);
      int n;
      if (p == 0) begin
         p0_val = 1'b1; p0_we = we; p0_addr = addr[9:0]; p0_wdata = d;
      end else begin
         p1_val = 1'b1; p1_we = we; p1_addr = addr[9:0]; p1_wdata = d;
      end
      n = 0;
      @(negedge clk);
      while (!(p == 0 ? p0_rdy : p1_rdy) && n < 500) begin
         n++;
         @(negedge clk);
      end
      if (n >= 500) check(1'b0, "req_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (p == 0) p0_val = 1'b0;
      else p1_val = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      bit d0, d1;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'd0;
      idle(2);
      rst = 1'b0;
      check(p0_rsp_val === 1'b0 && p1_rsp_val === 1'b0, "reset_rsp_val", {30'd0, p1_rsp_val, p0_rsp_val}, 32'd0);
      check(p0_rdata === 32'd0, "reset_p0_rdata", p0_rdata, 32'd0);
      check(p1_rdata === 32'd0, "reset_p1_rdata", p1_rdata, 32'd0);

      // Write then read back on port 0.
      req(0, 1'b1, 5, 32'hDEAD_BEEF);
      req(0, 1'b0, 5, 32'd0);
      idle(3);

      // Preload via port 1, then both ports read every cycle.
      req(1, 1'b1, 1, 32'h0000_0011);
      req(1, 1'b1, 2, 32'h0000_0022);
      idle(3);
      fork
         begin repeat (6) req(0, 1'b0, 1, 32'd0); end
         begin repeat (6) req(1, 1'b0, 2, 32'd0); end
      join
      idle(3);

      // Port 1 response held under back-pressure while port 0 overwrites.
      req(0, 1'b1, 7, 32'h0000_0033);
      idle(3);
      p1_rsp_rdy = 1'b0;
      fork
         begin req(1, 1'b0, 7, 32'd0); req(1, 1'b0, 7, 32'd0); end
         begin idle(1); req(0, 1'b1, 7, 32'h0000_0055); end
         begin idle(7); p1_rsp_rdy = 1'b1; end
      join
      idle(3);

      // Same-cycle write and read of addr 9 after a reset.
      rst = 1'b1; idle(1); rst = 1'b0;
      fork
         req(0, 1'b1, 9, 32'h0000_00A5);
         req(1, 1'b0, 9, 32'd0);
      join
      idle(3);

      // Reset right after a read accept drops the response.
      req(0, 1'b0, 9, 32'd0);
      rst = 1'b1; idle(1); rst = 1'b0;
      idle(3);
      fork
         req(0, 1'b0, 9, 32'd0);
         req(1, 1'b0, 5, 32'd0);
      join
      idle(3);

      for (int a = 0; a < 16; a++) req(0, 1'b1, a, $urandom);
      idle(3);
      for (int a = 0; a < 8; a++) req(0, 1'b0, a, 32'd0);
      idle(3);

      // Random traffic with random response back-pressure.
      d0 = 1'b0; d1 = 1'b0;
      fork
         begin
            repeat (300) begin
               req(0, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
               idle($urandom_range(0, 2));
            end
            d0 = 1'b1;
         end
         begin
            repeat (300) begin
               req(1, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom);
               idle($urandom_range(0, 2));
            end
            d1 = 1'b1;
         end
         begin
            while (!(d0 && d1)) begin
               idle(1);
               p0_rsp_rdy = 1'($urandom_range(0, 1));
               p1_rsp_rdy = 1'($urandom_range(0, 1));
            end
            p0_rsp_rdy = 1'b1;
            p1_rsp_rdy = 1'b1;
         end
      join
      idle(8);
      check(q0.size() == 0 && q1.size() == 0, "drain", q0.size() + q1.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
      $fatal(1);
   end

endmodule
